// File: rtl/vga_pixel_fetcher.sv
// Double-buffered line fetcher: pulls the next framebuffer line into a back buffer
// while the current line is scanned out of the display buffer as RGB888.
module vga_pixel_fetcher #(
    parameter logic [31:0] FRAMEBUFFER_BASE = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  pixel_x_pos,
    input  logic [9:0]  pixel_y_pos,
    output logic [7:0]  pixel_red,
    output logic [7:0]  pixel_green,
    output logic [7:0]  pixel_blue,
    output logic        mem_read_request,
    output logic [31:0] mem_address,
    input  logic        mem_read_ack,
    input  logic [31:0] mem_read_data,
    output logic        underrun
);

    localparam int unsigned WORDS_PER_LINE = 160;
    localparam int unsigned BYTES_PER_LINE = 640;
    localparam int unsigned LAST_LINE      = 479;
    localparam int unsigned IDX_W          = 8;
    localparam int unsigned LINE_W         = 9;

    typedef enum logic [1:0] {
        PRIME0,
        PRIME1,
        IDLE,
        FETCH
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [LINE_W-1:0]   r_line;
    logic [9:0]          r_last_y;
    logic                r_sel;
    logic                r_req;
    logic [31:0]         r_addr;
    logic                r_underrun;
    logic [7:0]          r_red;
    logic [7:0]          r_green;
    logic [7:0]          r_blue;

    logic [31:0]         r_buf0 [WORDS_PER_LINE];
    logic [31:0]         r_buf1 [WORDS_PER_LINE];

    logic                w_line_ev;
    logic [LINE_W-1:0]   w_next_line;
    logic                w_ack;
    logic                w_abort;
    logic                w_wr_en;
    logic                w_wr_buf;
    logic                w_last_word;
    logic [31:0]         w_req_addr;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [31:0]         w_rd_word;
    logic [7:0]          w_byte;
    logic [2:0]          w_r;
    logic [2:0]          w_g;
    logic [1:0]          w_b;

    assign mem_read_request = r_req;
    assign mem_address      = r_addr;
    assign underrun         = r_underrun;
    assign pixel_red        = r_red;
    assign pixel_green      = r_green;
    assign pixel_blue       = r_blue;

    // A new scan line is signalled purely by the y position changing.
    assign w_line_ev   = (pixel_y_pos != r_last_y);
    assign w_next_line = (pixel_y_pos >= 10'(LAST_LINE)) ? '0 : LINE_W'(pixel_y_pos + 10'd1);

    // Acks only count while a request is actually outstanding.
    assign w_ack       = r_req && mem_read_ack;
    assign w_abort     = (r_state == FETCH) && w_line_ev;
    assign w_wr_en     = w_ack && !w_abort;
    // Priming line 0 fills the display buffer; every other fetch fills the back buffer.
    assign w_wr_buf    = (r_state == PRIME0) ? r_sel : ~r_sel;
    assign w_last_word = (r_idx == IDX_W'(WORDS_PER_LINE - 1));
    assign w_req_addr  = FRAMEBUFFER_BASE
                       + (32'(r_line) * 32'(BYTES_PER_LINE))
                       + (32'(r_idx) << 2);

    // Out-of-range x positions read word 0 instead of indexing past the buffer.
    assign w_rd_idx  = (pixel_x_pos[9:2] < IDX_W'(WORDS_PER_LINE)) ? pixel_x_pos[9:2] : '0;
    assign w_rd_word = r_sel ? r_buf1[w_rd_idx] : r_buf0[w_rd_idx];

    // Pick the RGB332 byte for this pixel within its word (byte 0 is leftmost).
    always_comb begin
        w_byte = w_rd_word[7:0];
        case (pixel_x_pos[1:0])
            2'd1:    w_byte = w_rd_word[15:8];
            2'd2:    w_byte = w_rd_word[23:16];
            2'd3:    w_byte = w_rd_word[31:24];
            default: w_byte = w_rd_word[7:0];
        endcase
    end

    assign w_r = w_byte[7:5];
    assign w_g = w_byte[4:2];
    assign w_b = w_byte[1:0];

    // Register the bit-replicated RGB888 colour one cycle after the x position.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= {w_r, w_r, w_r[2:1]};
            r_green <= {w_g, w_g, w_g[2:1]};
            r_blue  <= {w_b, w_b, w_b, w_b};
        end
    end

    // Line buffer write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (!reset && w_wr_en) begin
            if (w_wr_buf) begin
                r_buf1[r_idx] <= mem_read_data;
            end else begin
                r_buf0[r_idx] <= mem_read_data;
            end
        end
    end

    // Fetch sequencer: prime two lines, then fetch one line ahead on every line event.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= PRIME0;
            r_idx      <= '0;
            r_line     <= '0;
            r_last_y   <= '0;
            r_sel      <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= FRAMEBUFFER_BASE;
            r_underrun <= 1'b0;
        end else begin
            r_last_y <= pixel_y_pos;
            if (r_state == IDLE) begin
                if (w_line_ev) begin
                    r_sel   <= ~r_sel;
                    r_line  <= w_next_line;
                    r_idx   <= '0;
                    r_state <= FETCH;
                end
            end else if (w_abort) begin
                // Scan-out overtook the fetch: flag it and chase the new line from word 0.
                r_underrun <= 1'b1;
                r_sel      <= ~r_sel;
                r_line     <= w_next_line;
                r_idx      <= '0;
                r_req      <= 1'b0;
            end else if (w_ack) begin
                r_req <= 1'b0;
                if (w_last_word) begin
                    r_idx <= '0;
                    if (r_state == PRIME0) begin
                        r_state <= PRIME1;
                        r_line  <= LINE_W'(1);
                    end else begin
                        r_state <= IDLE;
                    end
                end else begin
                    r_idx <= r_idx + 8'd1;
                end
            end else if (!r_req) begin
                r_req  <= 1'b1;
                r_addr <= w_req_addr;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
// Scoreboard bench for vga_pixel_fetcher: queued expected addresses and pixels,
// a latency-programmable memory responder, and a pixel monitor.
module tb_vga_pixel_fetcher;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int unsigned MAX_OFF = 307196;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x_pos;
    logic [9:0]  pixel_y_pos;
    logic [7:0]  pixel_red;
    logic [7:0]  pixel_green;
    logic [7:0]  pixel_blue;
    logic        mem_read_request;
    logic [31:0] mem_address;
    logic        mem_read_ack;
    logic [31:0] mem_read_data;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_addr[$];
    logic [23:0] q_pix[$];
    logic        pix_vld   = 1'b0;
    logic        pix_vld_d = 1'b0;

    int          mem_lat    = 0;
    bit          mem_pend   = 1'b0;
    int          mem_cnt    = 0;
    logic [31:0] mem_cur    = '0;
    bit          inject_ack = 1'b0;

    int          prev_tgt;
    int          disp;
    int          seen;
    int          ys[9] = '{1, 2, 5, 6, 477, 478, 479, 0, 1};

    always #5 clock = ~clock;

    vga_pixel_fetcher #(.FRAMEBUFFER_BASE(BASE)) dut (
        .clock           (clock),
        .reset           (reset),
        .pixel_x_pos     (pixel_x_pos),
        .pixel_y_pos     (pixel_y_pos),
        .pixel_red       (pixel_red),
        .pixel_green     (pixel_green),
        .pixel_blue      (pixel_blue),
        .mem_read_request(mem_read_request),
        .mem_address     (mem_address),
        .mem_read_ack    (mem_read_ack),
        .mem_read_data   (mem_read_data),
        .underrun        (underrun)
    );

    // Framebuffer contents: a fixed word at pixel (0,0), hashed data elsewhere.
    function automatic logic [31:0] fb_word(input logic [31:0] addr);
        if (addr == BASE) return 32'h03E0_1CFF;
        return (addr * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    // Expected RGB888 for pixel x of a framebuffer line.
    function automatic logic [23:0] ref_pixel(input int line, input int x);
        logic [31:0] w;
        int b, r, g, bl;
        w  = fb_word(BASE + 32'(line * 640 + (x / 4) * 4));
        b  = int'((w >> (8 * (x % 4))) & 32'hFF);
        r  = b / 32;
        g  = (b / 4) % 8;
        bl = b % 4;
        return {8'(r * 32 + r * 4 + r / 2), 8'(g * 32 + g * 4 + g / 2), 8'(bl * 85)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_line(input int line);
        for (int w = 0; w < 160; w++) q_addr.push_back(BASE + 32'(line * 640 + w * 4));
    endtask

    // Scan x = 0..3 then random positions on the given displayed line.
    task automatic scan(input int line, input int n);
        int x;
        for (int i = 0; i < n; i++) begin
            x = (i < 4) ? i : int'($urandom_range(0, 639));
            pixel_x_pos = 10'(x);
            q_pix.push_back(ref_pixel(line, x));
            pix_vld = 1'b1;
            tick(1);
        end
        pix_vld = 1'b0;
        tick(2);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((q_addr.size() != 0 || mem_pend || mem_read_request) && t < 6000) begin
            tick(1);
            t++;
        end
        check(name, 32'(t < 6000), 32'd1);
        tick(3);
    endtask

    // Move to a new y; returns the line the block should now fetch.
    task automatic line_event(input int y, output int tgt);
        pixel_y_pos = 10'(y);
        tick(1);
        tgt = (y == 479) ? 0 : y + 1;
        q_addr.delete();
        push_line(tgt);
    endtask

    // Memory responder and request monitor, acting away from the active edge.
    always @(negedge clock) begin
        mem_read_ack = 1'b0;
        if (inject_ack) begin
            mem_read_ack  = 1'b1;
            mem_read_data = 32'hDEAD_BEEF;
            inject_ack    = 1'b0;
        end else if (mem_pend && !mem_read_request) begin
            mem_pend = 1'b0;
        end else if (mem_pend) begin
            check("addr_stable", mem_address, mem_cur);
            if (mem_cnt == 0) begin
                mem_read_ack  = 1'b1;
                mem_read_data = fb_word(mem_cur);
                mem_pend      = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (mem_read_request && !reset) begin
            if (q_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got %h expected none at %0t", mem_address, $time);
            end else begin
                check("req_addr", mem_address, q_addr.pop_front());
            end
            check("addr_range", 32'((mem_address - BASE) <= MAX_OFF), 32'd1);
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_cur  = mem_address;
        end
    end

    always @(posedge clock) pix_vld_d <= pix_vld;

    // Pixel monitor: compares the registered colour one cycle after each scanned x.
    always @(negedge clock) begin
        if (pix_vld_d) begin
            if (q_pix.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_underflow: got output with no expectation at %0t", $time);
            end else begin
                check("pixel", 32'({pixel_red, pixel_green, pixel_blue}), 32'(q_pix.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        pixel_x_pos   = '0;
        pixel_y_pos   = '0;
        mem_read_ack  = 1'b0;
        mem_read_data = '0;
        tick(3);
        check("rst_rgb", 32'({pixel_red, pixel_green, pixel_blue}), 32'd0);
        check("rst_req", 32'(mem_read_request), 32'd0);
        check("rst_addr", mem_address, BASE);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Prime lines 0 and 1 with a one-cycle memory.
        push_line(0);
        push_line(1);
        mem_lat = 0;
        reset   = 1'b0;
        tick(1);
        check("req_after_reset", 32'(mem_read_request), 32'd1);
        check("first_addr", mem_address, BASE);
        wait_done("prime_done");
        check("prime_underrun", 32'(underrun), 32'd0);

        // Idle: an ack with no request must change nothing and trigger no fetch.
        inject_ack = 1'b1;
        seen = 0;
        repeat (40) begin
            tick(1);
            if (mem_read_request) seen++;
        end
        check("idle_quiet", 32'(seen), 32'd0);
        scan(0, 30);

        // Normal line events with random short memory latency.
        prev_tgt = 1;
        foreach (ys[i]) begin
            mem_lat = int'($urandom_range(0, 3));
            disp = prev_tgt;
            line_event(ys[i], prev_tgt);
            scan(disp, 24);
            wait_done("fetch_done");
            check("no_underrun", 32'(underrun), 32'd0);
        end

        // Late memory: fetches cannot finish between line events.
        mem_lat = 19;
        line_event(10, prev_tgt);
        tick(790);
        check("late_before", 32'(underrun), 32'd0);
        line_event(11, prev_tgt);
        tick(2);
        check("late_underrun", 32'(underrun), 32'd1);
        tick(798);
        line_event(12, prev_tgt);
        wait_done("late_recover");
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Reset in the middle of a fetch with a read outstanding.
        line_event(20, prev_tgt);
        tick(30);
        check("read_outstanding", 32'(mem_pend), 32'd1);
        reset       = 1'b1;
        pixel_y_pos = '0;
        tick(1);
        check("midrst_req", 32'(mem_read_request), 32'd0);
        check("midrst_addr", mem_address, BASE);
        tick(1);
        check("midrst_underrun", 32'(underrun), 32'd0);
        q_addr.delete();
        push_line(0);
        push_line(1);
        mem_lat    = 0;
        reset      = 1'b0;
        inject_ack = 1'b1;
        tick(1);
        check("reprime_req", 32'(mem_read_request), 32'd1);
        check("reprime_addr", mem_address, BASE);
        wait_done("reprime_done");
        check("reprime_underrun", 32'(underrun), 32'd0);
        scan(0, 20);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
